// File: rtl/load_store_unit_if.sv
// Word-wide data-memory bus between the load/store unit (master) and memory (slave).
// Byte lanes are little-endian: MemBE[i] qualifies MemWData/MemRData bits [8*i+7:8*i].
interface load_store_unit_if;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemBE;
    logic [31:0] MemWData;
    logic        MemReady;
    logic [31:0] MemRData;

    modport master (
        output MemReq,
        output MemWe,
        output MemAddr,
        output MemBE,
        output MemWData,
        input  MemReady,
        input  MemRData
    );

    modport slave (
        input  MemReq,
        input  MemWe,
        input  MemAddr,
        input  MemBE,
        input  MemWData,
        output MemReady,
        output MemRData
    );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V byte/half/word load-store front end with a request/ready memory handshake.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses instead of truncating).
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Stall,
    output logic [WIDTH-1:0] LoadData,
    output logic             LoadValid,
    output logic             MisalignErr,
    load_store_unit_if.master mem
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    state_t      state_r;
    logic [2:0]  f3_r;
    logic [1:0]  lane_r;
    logic        is_store_r;
    logic [31:0] load_data_r;
    logic        load_valid_r;
    logic        misalign_err_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_wdata_r;

    logic        req_s;
    logic        misalign_s;

    // Funct3[1:0] carries the size (00 byte, 01 half, 1x word); the 011/11x aliases fall into word.
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

    assign misalign_s = is_misaligned(Funct3[1:0], ALUResult[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    assign req_s = MemRead | MemWrite;

    // Stall must drop while reset is held even if the pipeline keeps a request asserted.
    assign Stall = rst_n & (((state_r == ST_IDLE) & req_s) | (state_r == ST_ACCESS));

    assign LoadData     = load_data_r;
    assign LoadValid    = load_valid_r;
    assign MisalignErr  = misalign_err_r;
    assign mem.MemReq   = mem_req_r;
    assign mem.MemWe    = mem_we_r;
    assign mem.MemAddr  = mem_addr_r;
    assign mem.MemBE    = mem_be_r;
    assign mem.MemWData = mem_wdata_r;

    // Access sequencer: capture in IDLE, hold the bus in ACCESS, retire and pulse status in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            f3_r           <= 3'b000;
            lane_r         <= 2'b00;
            is_store_r     <= 1'b0;
            load_data_r    <= 32'd0;
            load_valid_r   <= 1'b0;
            misalign_err_r <= 1'b0;
            mem_req_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= 32'd0;
            mem_be_r       <= 4'b0000;
            mem_wdata_r    <= 32'd0;
        end else begin
            load_valid_r   <= 1'b0;
            misalign_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        f3_r       <= Funct3;
                        lane_r     <= ALUResult[1:0];
                        is_store_r <= MemWrite;
                        if (misalign_s) begin
                            // Trapped accesses never reach memory.
                            misalign_err_r <= 1'b1;
                            state_r        <= ST_DONE;
                        end else begin
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= MemWrite;
                            mem_addr_r  <= {ALUResult[31:2], 2'b00};
                            mem_be_r    <= byte_enables(Funct3[1:0], ALUResult[1:0]);
                            mem_wdata_r <= MemWrite ? store_lanes(Funct3[1:0], WriteData) : 32'd0;
                            state_r     <= ST_ACCESS;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (mem.MemReady) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        state_r   <= ST_DONE;
                        if (!is_store_r) begin
                            load_data_r  <= load_extract(f3_r, lane_r, mem.MemRData);
                            load_valid_r <= 1'b1;
                        end else begin
                            load_valid_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
